mem_port_arbiter: RTL and testbench

- Shares the single data-SRAM-like memory port between the instruction-fetch requester (IF) and the load/store requester (EXE issue / MEM return).
- Grants one request per address handshake.
- Keeps the requester order of outstanding transactions in an ID FIFO, and routes each in-order response (data_ok/rdata) back to its owner.
- Sits between the pipeline stages and the memory bridge; MEM consumes data_rdata exactly as today.

---
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and load/store requesters onto one memory port and
// returns each in-order response to the requester that issued it.
module mem_port_arbiter #(
    parameter int MAX_OUTST = 2,
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         inst_req,
    input  logic [31:0]                  inst_addr,
    output logic                         inst_addr_ok,
    output logic                         inst_data_ok,
    output logic [31:0]                  inst_rdata,
    input  logic                         data_req,
    input  logic                         data_wr,
    input  logic [1:0]                   data_size,
    input  logic [31:0]                  data_addr,
    input  logic [3:0]                   data_wstrb,
    input  logic [31:0]                  data_wdata,
    output logic                         data_addr_ok,
    output logic                         data_data_ok,
    output logic [31:0]                  data_rdata,
    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [31:0]                  mem_addr,
    output logic [3:0]                   mem_wstrb,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [31:0]                  mem_rdata,
    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         rsp_err
);
    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t               state_q, state_d;
    logic                 gnt_i, gnt_d;
    logic                 full, push, pop, head;
    logic [MAX_OUTST-1:0] fifo_q;
    logic [PW-1:0]        wptr_q, rptr_q;
    logic [CW-1:0]        cnt_q;
    logic                 err_q;

    assign full = (cnt_q == CW'(MAX_OUTST));

    // A stalled request keeps its grant so its fields stay stable until accepted.
    always_comb begin
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                gnt_d = data_req & (DATA_PRIO | ~inst_req);
                gnt_i = inst_req & ~gnt_d;
                if ((inst_req | data_req) && !full && !mem_addr_ok)
                    state_d = gnt_d ? LOCK_D : LOCK_I;
            end
            LOCK_I: begin
                gnt_i = inst_req;
                if (!inst_req || (!full && mem_addr_ok))
                    state_d = IDLE;
            end
            LOCK_D: begin
                gnt_d = data_req;
                if (!data_req || (!full && mem_addr_ok))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_wr    = 1'b0;
        mem_size  = 2'd0;
        mem_addr  = 32'd0;
        mem_wstrb = 4'd0;
        mem_wdata = 32'd0;
        if (gnt_d) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wstrb = data_wstrb;
            mem_wdata = data_wdata;
        end else if (gnt_i) begin
            mem_size  = 2'd2;
            mem_addr  = inst_addr;
        end
    end

    assign mem_req      = (gnt_i | gnt_d) & ~full;
    assign push         = mem_req & mem_addr_ok;
    assign inst_addr_ok = push & gnt_i;
    assign data_addr_ok = push & gnt_d;

    assign pop          = mem_data_ok & (cnt_q != '0);
    assign head         = fifo_q[rptr_q];
    assign inst_data_ok = pop & ~head;
    assign data_data_ok = pop & head;
    assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;

    assign outst_cnt    = cnt_q;
    assign rsp_err      = err_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            fifo_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                fifo_q[wptr_q] <= gnt_d;
                wptr_q         <= wptr_q + PW'(1);
            end
            if (pop)
                rptr_q <= rptr_q + PW'(1);
            if (push && !pop)
                cnt_q <= cnt_q + CW'(1);
            else if (pop && !push)
                cnt_q <= cnt_q - CW'(1);
            if (mem_data_ok && cnt_q == '0)
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed
// corner sequences, and random traffic against an owner-queue model.
module tb_mem_port_arbiter;
    localparam int MAXO = 2;
    localparam bit DPRIO = 1'b1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata, mem_rdata;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [1:0]  outst_cnt;
    logic        rsp_err;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_OUTST(MAXO), .DATA_PRIO(DPRIO)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .outst_cnt(outst_cnt), .rsp_err(rsp_err)
    );

    typedef struct {
        logic        ir, dr, dwr, maok;
        logic        e_mreq, e_mwr;
        logic [31:0] e_maddr;
        logic        e_iaok, e_daok;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of owners (1 = data) plus the requester
    // that was presented but not yet accepted (0 none, 1 inst, 2 data).
    bit q[$];
    int pend;
    bit err_m;

    task automatic model_step();
        int sel;
        bit full, mreq, push, pop, hd;
        logic [70:0] ef;
        if (pend == 1) sel = inst_req ? 1 : 0;
        else if (pend == 2) sel = data_req ? 2 : 0;
        else if (inst_req && data_req) sel = DPRIO ? 2 : 1;
        else if (data_req) sel = 2;
        else if (inst_req) sel = 1;
        else sel = 0;
        full = (q.size() == MAXO);
        mreq = (sel != 0) && !full;
        push = mreq && mem_addr_ok;
        pop  = mem_data_ok && q.size() != 0;
        hd   = (q.size() != 0) ? q[0] : 1'b0;
        if (sel == 2)
            ef = {data_wr, data_size, data_addr, data_wstrb, data_wdata};
        else if (sel == 1)
            ef = {1'b0, 2'd2, inst_addr, 4'd0, 32'd0};
        else
            ef = '0;
        chk("mem_req", 32'(mem_req), 32'(mreq));
        chk("mem_addr", mem_addr, ef[67:36]);
        chk("mem_wdata", mem_wdata, ef[31:0]);
        chk("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb},
            {25'd0, ef[70], ef[69:68], ef[35:32]});
        chk("addr_ok", {inst_addr_ok, data_addr_ok},
            {push && sel == 1, push && sel == 2});
        chk("data_ok", {inst_data_ok, data_data_ok}, {pop && !hd, pop && hd});
        chk("inst_rdata", inst_rdata, (pop && !hd) ? mem_rdata : 32'd0);
        chk("data_rdata", data_rdata, (pop && hd) ? mem_rdata : 32'd0);
        chk("outst_cnt", 32'(outst_cnt), q.size());
        chk("rsp_err", 32'(rsp_err), 32'(err_m));
        if (mem_data_ok && q.size() == 0) err_m = 1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(sel == 2);
        if (push) pend = 0;
        else if (pend != 0 && sel == 0) pend = 0;
        else if (pend == 0 && mreq && !mem_addr_ok) pend = sel;
    endtask

    initial begin
        idle_inputs();
        resetn = 0;

        tbl[0] = '{0, 0, 0, 0, 0, 0, 32'h0, 0, 0};
        tbl[1] = '{1, 0, 0, 1, 1, 0, 32'h1c000000, 1, 0};
        tbl[2] = '{0, 1, 1, 1, 1, 1, 32'h2000, 0, 1};
        tbl[3] = '{1, 1, 0, 1, 1, 0, 32'h2000, 0, 1};
        tbl[4] = '{1, 1, 1, 0, 1, 1, 32'h2000, 0, 0};
        tbl[5] = '{1, 0, 0, 0, 1, 0, 32'h1c000000, 0, 0};
        tbl[6] = '{0, 1, 0, 0, 1, 0, 32'h2000, 0, 0};

        do_reset();
        @(negedge clk);
        chk("rst_cnt", 32'(outst_cnt), 0);
        chk("rst_err", 32'(rsp_err), 0);
        chk("rst_outs", {mem_req, inst_addr_ok, data_addr_ok,
            inst_data_ok, data_data_ok}, 0);
        chk("rst_maddr", mem_addr, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            inst_req = tbl[i].ir; inst_addr = 32'h1c000000;
            data_req = tbl[i].dr; data_wr = tbl[i].dwr;
            data_addr = 32'h2000; data_size = 2;
            mem_addr_ok = tbl[i].maok;
            @(negedge clk);
            chk($sformatf("vec%0d_mreq", i), 32'(mem_req), 32'(tbl[i].e_mreq));
            chk($sformatf("vec%0d_mwr", i), 32'(mem_wr), 32'(tbl[i].e_mwr));
            chk($sformatf("vec%0d_maddr", i), mem_addr, tbl[i].e_maddr);
            chk($sformatf("vec%0d_aok", i), {inst_addr_ok, data_addr_ok},
                {tbl[i].e_iaok, tbl[i].e_daok});
        end

        // single load
        do_reset();
        data_req = 1; data_size = 2; data_addr = 32'h1000; mem_addr_ok = 1;
        @(negedge clk);
        chk("ld_aok", 32'(data_addr_ok), 1);
        chk("ld_addr", mem_addr, 32'h1000);
        nxt(); data_req = 0; mem_addr_ok = 0;
        @(negedge clk);
        chk("ld_cnt1", 32'(outst_cnt), 1);
        chk("ld_dok_early", 32'(data_data_ok), 0);
        nxt(); mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("ld_dok", {inst_data_ok, data_data_ok}, 2'b01);
        chk("ld_rdata", data_rdata, 32'hDEADBEEF);
        nxt(); mem_data_ok = 0;
        @(negedge clk);
        chk("ld_cnt0", 32'(outst_cnt), 0);

        // simultaneous store + fetch
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000000;
        data_req = 1; data_wr = 1; data_addr = 32'h2000;
        data_wstrb = 4'b0011; data_size = 2; mem_addr_ok = 1;
        @(negedge clk);
        chk("sim_d_first", {inst_addr_ok, data_addr_ok}, 2'b01);
        chk("sim_d_ctl", {mem_wr, mem_wstrb}, 5'b10011);
        nxt(); data_req = 0;
        @(negedge clk);
        chk("sim_i_next", {inst_addr_ok, data_addr_ok}, 2'b10);
        chk("sim_i_ctl", {mem_wr, mem_size}, 3'b010);
        chk("sim_i_addr", mem_addr, 32'h1c000000);
        nxt(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        @(negedge clk);
        chk("sim_rsp1", {inst_data_ok, data_data_ok}, 2'b01);
        nxt();
        @(negedge clk);
        chk("sim_rsp2", {inst_data_ok, data_data_ok}, 2'b10);
        nxt(); mem_data_ok = 0;

        // lock holds inst fields while data request arrives
        do_reset();
        inst_req = 1; inst_addr = 32'h1c000000;
        @(negedge clk);
        chk("lk_c0", mem_addr, 32'h1c000000);
        nxt(); data_req = 1; data_addr = 32'h3000; data_size = 2;
        for (int c = 1; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("lk_c%0d_addr", c), mem_addr, 32'h1c000000);
            chk($sformatf("lk_c%0d_aok", c), {inst_addr_ok, data_addr_ok}, 0);
            nxt();
        end
        mem_addr_ok = 1;
        @(negedge clk);
        chk("lk_i_aok", {inst_addr_ok, data_addr_ok}, 2'b10);
        nxt(); inst_req = 0;
        @(negedge clk);
        chk("lk_d_aok", {inst_addr_ok, data_addr_ok}, 2'b01);
        chk("lk_d_addr", mem_addr, 32'h3000);
        nxt(); data_req = 0; mem_addr_ok = 0;

        // full
        do_reset();
        data_req = 1; data_addr = 32'h4000; data_size = 2; mem_addr_ok = 1;
        nxt(); nxt(); inst_req = 1; inst_addr = 32'h1c000000;
        @(negedge clk);
        chk("full_cnt", 32'(outst_cnt), 2);
        chk("full_block", {mem_req, inst_addr_ok, data_addr_ok}, 0);
        nxt(); inst_req = 0; mem_data_ok = 1;
        @(negedge clk);
        chk("full_pop", {mem_req, data_data_ok}, 2'b01);
        nxt(); mem_data_ok = 0;
        @(negedge clk);
        chk("full_reissue", {mem_req, data_addr_ok}, 2'b11);
        chk("full_cnt1", 32'(outst_cnt), 1);
        nxt(); data_req = 0; mem_addr_ok = 0;

        // push+pop at count 1, then spurious response
        do_reset();
        data_req = 1; mem_addr_ok = 1;
        nxt(); data_req = 0; inst_req = 1; mem_data_ok = 1;
        mem_rdata = 32'h11112222;
        @(negedge clk);
        chk("pp_aok", {inst_addr_ok, data_data_ok, inst_data_ok}, 3'b110);
        nxt(); inst_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        @(negedge clk);
        chk("pp_cnt", 32'(outst_cnt), 1);
        nxt(); mem_data_ok = 1; mem_rdata = 32'h33334444;
        @(negedge clk);
        chk("pp_inst_dok", {inst_data_ok, data_data_ok}, 2'b10);
        chk("pp_irdata", inst_rdata, 32'h33334444);
        nxt();
        @(negedge clk);
        chk("sp_no_dok", {inst_data_ok, data_data_ok, rsp_err}, 0);
        nxt(); mem_data_ok = 0;
        @(negedge clk);
        chk("sp_err", {30'd0, rsp_err, 1'b0} | 32'(outst_cnt), 2);

        // reset with outstanding work and a data lock
        data_req = 1; mem_addr_ok = 1;
        nxt(); mem_addr_ok = 0;
        nxt();
        idle_inputs(); resetn = 0;
        nxt();
        @(negedge clk);
        chk("rr_state", {inst_addr_ok, data_addr_ok, inst_data_ok,
            data_data_ok, rsp_err}, 0);
        chk("rr_cnt", 32'(outst_cnt), 0);
        #1 resetn = 1; @(posedge clk); #1;
        inst_req = 1; inst_addr = 32'h1c000000; mem_addr_ok = 1;
        @(negedge clk);
        chk("rr_idle", {inst_addr_ok, data_addr_ok}, 2'b10);
        nxt();

        // random traffic against the model
        do_reset();
        q.delete(); pend = 0; err_m = 0;
        for (int c = 0; c < 2000; c++) begin
            inst_req    = ($urandom_range(0, 3) != 0);
            inst_addr   = $urandom;
            data_req    = ($urandom_range(0, 2) != 0);
            data_wr     = 1'($urandom);
            data_size   = 2'($urandom_range(0, 2));
            data_addr   = $urandom;
            data_wstrb  = 4'($urandom);
            data_wdata  = $urandom;
            mem_addr_ok = 1'($urandom);
            mem_data_ok = ($urandom_range(0, 9) < 4);
            mem_rdata   = $urandom;
            @(negedge clk);
            model_step();
            nxt();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
